// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris scoring datapath.
package tetris_pkg;

    localparam int unsigned SCORE_W = 20;
    localparam int unsigned BASE_W  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Base points indexed by (lines cleared - 1): single, double, triple, tetris.
    localparam logic [3:0][BASE_W-1:0] BASE_PTS = {11'd1200, 11'd300, 11'd100, 11'd40};

endpackage

// File: rtl/score_keeper.sv
// Score, line and level bookkeeping: multiplies base points by (level+1)
// through repeated addition, then commits the result with saturation.
module score_keeper
    import tetris_pkg::*;
#(
    parameter int unsigned MAX_SCORE       = 999999,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 29
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               clear_valid,
    input  logic [2:0]         clear_count,
    output logic               busy,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [11:0]        lines,
    output logic [4:0]         level,
    output logic               score_update,
    output logic               level_up
);

    localparam int unsigned LINES_W = 12;
    localparam int unsigned LEVEL_W = 5;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned CNT_W   = (LINES_PER_LEVEL > 1) ? $clog2(LINES_PER_LEVEL) : 1;
    localparam int unsigned SUM_W   = CNT_W + 3;

    state_e               state_q, state_d;
    logic [BASE_W-1:0]    base_q, base_d;
    logic [LEVEL_W-1:0]   mult_q, mult_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [2:0]           count_q, count_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_q, high_d;
    logic [LINES_W-1:0]   lines_q, lines_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     lvl_cnt_q, lvl_cnt_d;
    logic                 busy_q, busy_d;
    logic                 upd_q, upd_d;
    logic                 lvlup_q, lvlup_d;

    logic [SCORE_W:0]     score_sum;
    logic [LINES_W:0]     lines_sum;
    logic [SUM_W-1:0]     cnt_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            score_q   <= '0;
            high_q    <= '0;
            lines_q   <= '0;
            level_q   <= '0;
            lvl_cnt_q <= '0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b0;
            lvlup_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            score_q   <= score_d;
            high_q    <= high_d;
            lines_q   <= lines_d;
            level_q   <= level_d;
            lvl_cnt_q <= lvl_cnt_d;
            busy_q    <= busy_d;
            upd_q     <= upd_d;
            lvlup_q   <= lvlup_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        count_d   = count_q;
        score_d   = score_q;
        high_d    = high_q;
        lines_d   = lines_q;
        level_d   = level_q;
        lvl_cnt_d = lvl_cnt_q;
        upd_d     = 1'b0;
        lvlup_d   = 1'b0;

        // Sums are one bit wider than their registers so clamping never sees a wrap.
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(acc_q);
        lines_sum = {1'b0, lines_q} + (LINES_W+1)'(count_q);
        cnt_sum   = SUM_W'(lvl_cnt_q) + SUM_W'(count_q);

        if (new_game) begin
            state_d   = IDLE;
            base_d    = '0;
            mult_d    = '0;
            acc_d     = '0;
            count_d   = '0;
            score_d   = '0;
            lines_d   = '0;
            level_d   = '0;
            lvl_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_valid && (clear_count != 3'd0) && (clear_count <= 3'd4)) begin
                        base_d  = BASE_PTS[2'(clear_count - 3'd1)];
                        count_d = clear_count;
                        mult_d  = level_q + LEVEL_W'(1);
                        acc_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_d  = acc_q + ACC_W'(base_q);
                    mult_d = mult_q - LEVEL_W'(1);
                    if (mult_q == LEVEL_W'(1)) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    score_d = (score_sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                                    : score_sum[SCORE_W-1:0];
                    lines_d = lines_sum[LINES_W] ? {LINES_W{1'b1}} : lines_sum[LINES_W-1:0];
                    if (score_d > high_q) begin
                        high_d = score_d;
                    end
                    if (cnt_sum >= SUM_W'(LINES_PER_LEVEL)) begin
                        lvl_cnt_d = CNT_W'(cnt_sum - SUM_W'(LINES_PER_LEVEL));
                        if (level_q != LEVEL_W'(MAX_LEVEL)) begin
                            level_d = level_q + LEVEL_W'(1);
                            lvlup_d = 1'b1;
                        end
                    end else begin
                        lvl_cnt_d = CNT_W'(cnt_sum);
                    end
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign busy         = busy_q;
    assign score        = score_q;
    assign high_score   = high_q;
    assign lines        = lines_q;
    assign level        = level_q;
    assign score_update = upd_q;
    assign level_up     = lvlup_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// requests compared against a points/lines/level reference model.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game, clear_valid;
    logic [2:0]  clear_count;
    logic        busy, score_update, level_up;
    logic [19:0] score, high_score;
    logic [11:0] lines;
    logic [4:0]  level;

    logic        ng2, cv2;
    logic [2:0]  cc2;
    logic        busy2, upd2, lu2;
    logic [19:0] score2, hs2;
    logic [11:0] lines2;
    logic [4:0]  level2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_score, m_high, m_lines, m_level, m_cnt;
    localparam int M_MAX_SCORE = 999999;
    localparam int M_LPL       = 10;
    localparam int M_MAX_LEVEL = 29;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk(clk), .reset(rst), .new_game(new_game), .clear_valid(clear_valid),
        .clear_count(clear_count), .busy(busy), .score(score), .high_score(high_score),
        .lines(lines), .level(level), .score_update(score_update), .level_up(level_up)
    );

    score_keeper #(.MAX_SCORE(2000)) dut_lo (
        .clk(clk), .reset(rst), .new_game(ng2), .clear_valid(cv2),
        .clear_count(cc2), .busy(busy2), .score(score2), .high_score(hs2),
        .lines(lines2), .level(level2), .score_update(upd2), .level_up(lu2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_pts(input int c);
        case (c)
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
    endfunction

    task automatic model_clear_game();
        m_score = 0; m_lines = 0; m_level = 0; m_cnt = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_score"}, 32'(score), m_score);
        check({tag, "_high"},  32'(high_score), m_high);
        check({tag, "_lines"}, 32'(lines), m_lines);
        check({tag, "_level"}, 32'(level), m_level);
    endtask

    // Called at a negedge; returns at a negedge. Optionally pokes a second request while busy.
    task automatic send(input logic [2:0] c, input bit poke);
        int  cyc;
        int  exp_busy;
        bit  exp_lu;
        bit  acc;
        acc = (c >= 3'd1) && (c <= 3'd4);
        exp_busy = acc ? m_level + 2 : 0;
        exp_lu = 1'b0;
        if (acc) begin
            m_score = m_score + base_pts(int'(c)) * (m_level + 1);
            if (m_score > M_MAX_SCORE) m_score = M_MAX_SCORE;
            m_lines = m_lines + int'(c);
            if (m_lines > 4095) m_lines = 4095;
            m_cnt = m_cnt + int'(c);
            if (m_cnt >= M_LPL) begin
                m_cnt = m_cnt - M_LPL;
                if (m_level < M_MAX_LEVEL) begin
                    m_level++;
                    exp_lu = 1'b1;
                end
            end
            if (m_score > m_high) m_high = m_score;
        end
        clear_valid = 1'b1;
        clear_count = c;
        @(posedge clk); #1;
        clear_valid = 1'b0;
        clear_count = 3'd0;
        cyc = 0;
        if (poke && acc) begin
            clear_valid = 1'b1;
            clear_count = 3'd2;
            @(negedge clk);
            if (busy === 1'b1) cyc++;
            @(posedge clk); #1;
            clear_valid = 1'b0;
            clear_count = 3'd0;
        end
        @(negedge clk);
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cyc), 32'(exp_busy));
        check("score_update", 32'(score_update), 32'(acc));
        check("level_up", 32'(level_up), 32'(exp_lu));
        check_state("commit");
        @(negedge clk);
        check("update_one_cycle", 32'(score_update), 0);
        check("level_up_one_cycle", 32'(level_up), 0);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear_game();
        @(negedge clk);
        check("ng_busy", 32'(busy), 0);
        check_state("new_game");
    endtask

    initial begin
        int cyc;
        rst = 1'b1; new_game = 1'b0; clear_valid = 1'b0; clear_count = 3'd0;
        ng2 = 1'b0; cv2 = 1'b0; cc2 = 3'd0;
        m_high = 0;
        model_clear_game();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_update", 32'(score_update), 0);
        check("rst_level_up", 32'(level_up), 0);
        check_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Saturating instance: two tetrises at level 0 clamp at 2000
        for (int k = 0; k < 2; k++) begin
            cv2 = 1'b1; cc2 = 3'd4;
            @(posedge clk); #1;
            cv2 = 1'b0; cc2 = 3'd0;
            cyc = 0;
            @(negedge clk);
            while (busy2 === 1'b1 && cyc < 64) begin
                cyc++;
                @(negedge clk);
            end
            check("lo_busy", 32'(cyc), 2);
            check("lo_update", 32'(upd2), 1);
            check("lo_score", 32'(score2), (k == 0) ? 1200 : 2000);
        end
        check("lo_high", 32'(hs2), 2000);
        check("lo_lines", 32'(lines2), 8);
        check("lo_level", 32'(level2), 0);
        check("lo_level_up", 32'(lu2), 0);

        // Single tetris at level 0
        send(3'd4, 1'b0);
        do_new_game();

        // Ten singles reach level 1, then a single costs one extra cycle
        for (int k = 0; k < 10; k++) send(3'd1, 1'b0);
        check("ten_singles_score", 32'(score), 400);
        check("ten_singles_level", 32'(level), 1);
        send(3'd1, 1'b0);
        check("level1_single", 32'(score), 480);

        // Request while busy is dropped; zero count in idle is ignored
        send(3'd4, 1'b1);
        send(3'd0, 1'b0);
        send(3'd7, 1'b0);

        // new_game during ACCUM aborts without a pulse
        clear_valid = 1'b1; clear_count = 3'd4;
        @(posedge clk); #1;
        clear_valid = 1'b0; clear_count = 3'd0;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear_game();
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_update", 32'(score_update), 0);
        check_state("abort");
        @(negedge clk);
        check("abort_update_late", 32'(score_update), 0);

        // Randomized requests against the model
        for (int k = 0; k < 150; k++) begin
            logic [2:0] c;
            if ($urandom_range(0, 9) < 8) c = 3'($urandom_range(1, 4));
            else c = 3'($urandom_range(0, 7));
            send(c, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 49) == 0) do_new_game();
        end

        // Reset during ACCUM at level 3
        do_new_game();
        for (int k = 0; k < 8; k++) send(3'd4, 1'b0);
        check("pre_rst_level", 32'(level), 3);
        clear_valid = 1'b1; clear_count = 3'd4;
        @(posedge clk); #1;
        clear_valid = 1'b0; clear_count = 3'd0;
        @(negedge clk);
        check("mid_accum_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        m_high = 0;
        model_clear_game();
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_update", 32'(score_update), 0);
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_update", 32'(score_update), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        send(3'd2, 1'b0);
        check("post_rst_double", 32'(score), 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
